mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for the CPU load/store access unit
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Illegal size encodings are reported the same way as unaligned addresses.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] word,
    input  logic [WORD_W-1:0] store_data,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_data
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{(WORD_W-BYTE_W){is_signed & byte_lane[BYTE_W-1]}}, byte_lane};
            SZ_HALF: load_data = {{(WORD_W-HALF_W){is_signed & half_lane[HALF_W-1]}}, half_lane};
            default: load_data = word;
        endcase
    end

    // Only the addressed lane(s) take store data; the rest keep the word read from memory.
    always_comb begin
        merge_data = word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merge_data[7:0]   = store_data[BYTE_W-1:0];
                    2'd1:    merge_data[15:8]  = store_data[BYTE_W-1:0];
                    2'd2:    merge_data[23:16] = store_data[BYTE_W-1:0];
                    default: merge_data[31:24] = store_data[BYTE_W-1:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) merge_data[31:16] = store_data[HALF_W-1:0];
                else            merge_data[15:0]  = store_data[HALF_W-1:0];
            end
            default: merge_data = store_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store unit: alignment check, sub-word extract and read-modify-write
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_error
);

    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        accept, last_read, misaligned;

    logic        write_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [31:0] load_data, merge_data, word_addr;

    assign misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign word_addr  = {addr_q[31:2], 2'b00};

    mem_lane_align u_align (
        .size       (size_q),
        .is_signed  (signed_q),
        .addr_lo    (addr_q[1:0]),
        .word       (mem_rdata),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        last_read  = 1'b0;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_error = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = rst;
                if (req_valid && rst) begin
                    accept = 1'b1;
                    cnt_d  = CNT_INIT;
                    if (misaligned)                state_d = ST_RESP;
                    else if (!req_write)           state_d = ST_RD;
                    else if (req_size == SZ_WORD)  state_d = ST_WR;
                    else                           state_d = ST_RMW_RD;
                end
            end
            ST_RD, ST_RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = word_addr;
                if (cnt_q == 2'd0) begin
                    last_read = 1'b1;
                    if (state_q == ST_RD || mem_error) state_d = ST_RESP;
                    else                               state_d = ST_WR;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_WR: begin
                mem_write = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = wdata_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_error = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rdata_q stays zero for stores and for any failed access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_q  <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rdata_q  <= 32'd0;
                err_q    <= misaligned;
            end
            if (last_read) begin
                if (state_q == ST_RD) begin
                    err_q   <= mem_error;
                    rdata_q <= mem_error ? 32'd0 : load_data;
                end else if (mem_error) begin
                    err_q <= 1'b1;
                end else begin
                    wdata_q <= merge_data;
                end
            end
            if (state_q == ST_WR) err_q <= mem_error;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with directed load/store vectors
module tb_mem_access_unit;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write, mem_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] rdata; logic err; } resp_exp_t;
    typedef struct packed { logic [31:0] addr;  logic [31:0] len; } rd_exp_t;
    typedef struct packed { logic [31:0] addr;  logic [31:0] data; } wr_exp_t;

    resp_exp_t resp_q[$];
    rd_exp_t   rd_q[$];
    wr_exp_t   wr_q[$];

    mem_access_unit #(.READ_LATENCY(RL)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_error  (mem_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        resp_exp_t e;
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = resp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
            end
        end
    end

    // Memory-side monitor
    int      rd_run = 0;
    rd_exp_t rd_cur;
    logic    prev_write = 1'b0;
    always @(negedge clk) begin
        wr_exp_t w;
        check("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
        if (!mem_read && !mem_write) begin
            check("idle_mem_addr", mem_addr, 32'd0);
            check("idle_mem_wdata", mem_wdata, 32'd0);
        end
        if (mem_read) begin
            if (rd_run == 0) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 32'd1, 32'd0);
                    rd_cur = '{addr: mem_addr, len: 32'd0};
                end else begin
                    rd_cur = rd_q.pop_front();
                end
            end
            check("read_addr", mem_addr, rd_cur.addr);
            rd_run++;
        end else if (rd_run > 0) begin
            check("read_len", rd_run, rd_cur.len);
            rd_run = 0;
        end
        if (mem_write) begin
            if (prev_write) check("write_one_cycle", 32'd2, 32'd1);
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                w = wr_q.pop_front();
                check("write_addr", mem_addr, w.addr);
                check("write_data", mem_wdata, w.data);
            end
        end
        prev_write = mem_write;
    end

    task automatic txn(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] word,
                       input logic merr, input logic exp_read, input logic exp_write,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input int exp_cycles);
        int  cyc;
        bit  done;
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        if (exp_read)  rd_q.push_back('{addr: waddr, len: 32'(RL)});
        if (exp_write) wr_q.push_back('{addr: waddr, data: exp_wdata});
        resp_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        mem_rdata  = word;
        mem_error  = merr;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc  = 1;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1;
                break;
            end
            cyc++;
        end
        if (!done) check("txn_timeout", 32'd1, 32'd0);
        else       check("txn_cycles", cyc, exp_cycles);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0; mem_error = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", {31'd0, resp_error}, 32'd0);
        rst = 1'b1;
        #1 check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // loads: wr sz sg addr wdata memword merr | rd wr wdata | rdata err cycles
        txn(0, 2'b00, 1, 32'h0000_0003, 32'h0, 32'h80FF_FFFF, 0, 1, 0, 32'h0, 32'hFFFF_FF80, 0, RL + 2);
        txn(0, 2'b00, 0, 32'h0000_0001, 32'h0, 32'h1234_5678, 0, 1, 0, 32'h0, 32'h0000_0056, 0, RL + 2);
        txn(0, 2'b00, 1, 32'h0000_0002, 32'h0, 32'h007F_0000, 0, 1, 0, 32'h0, 32'h0000_007F, 0, RL + 2);
        txn(0, 2'b01, 1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 1, 0, 32'h0, 32'hFFFF_8001, 0, RL + 2);
        txn(0, 2'b01, 1, 32'h0000_0000, 32'h0, 32'h0000_8000, 0, 1, 0, 32'h0, 32'hFFFF_8000, 0, RL + 2);
        txn(0, 2'b01, 0, 32'h0000_0100, 32'h0, 32'h8001_F00D, 0, 1, 0, 32'h0, 32'h0000_F00D, 0, RL + 2);
        txn(0, 2'b10, 0, 32'h2000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 32'h0, 32'hDEAD_BEEF, 0, RL + 2);
        txn(0, 2'b10, 0, 32'h0000_0010, 32'h0, 32'hFFFF_FFFF, 1, 1, 0, 32'h0, 32'h0000_0000, 1, RL + 2);
        // misaligned / illegal size
        txn(0, 2'b10, 0, 32'h0000_0006, 32'h0, 32'h1234_5678, 0, 0, 0, 32'h0, 32'h0, 1, 2);
        txn(1, 2'b01, 0, 32'h0000_0011, 32'hFFFF, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 2);
        txn(0, 2'b11, 0, 32'h0000_0000, 32'h0, 32'h1234_5678, 0, 0, 0, 32'h0, 32'h0, 1, 2);
        // stores
        txn(1, 2'b01, 0, 32'h0000_0002, 32'hABCD_1234, 32'h1111_1111, 0, 1, 1, 32'h1234_1111, 32'h0, 0, RL + 3);
        txn(1, 2'b00, 0, 32'h0000_0041, 32'h5A5A_5AA5, 32'hFFFF_FFFF, 0, 1, 1, 32'hFFFF_A5FF, 32'h0, 0, RL + 3);
        txn(1, 2'b10, 0, 32'h0000_0080, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 32'hCAFE_F00D, 32'h0, 0, 3);
        txn(1, 2'b10, 0, 32'h0000_0084, 32'h0123_4567, 32'h0, 1, 0, 1, 32'h0123_4567, 32'h0, 1, 3);
        txn(1, 2'b00, 0, 32'h0000_0008, 32'h0000_0077, 32'h1122_3344, 1, 1, 0, 32'h0, 32'h0, 1, RL + 2);

        // reset while in RD: access is abandoned
        rd_q.push_back('{addr: 32'h0000_0040, len: 32'd1});
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h0000_0040;
        mem_rdata = 32'h5555_AAAA; mem_error = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_rd_mem_read", {31'd0, mem_read}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_mem_read", {31'd0, mem_read}, 32'd0);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b1;
        #1 check("abort_ready", {31'd0, req_ready}, 32'd1);

        txn(0, 2'b00, 1, 32'h0000_0044, 32'h0, 32'h0000_00C3, 0, 1, 0, 32'h0, 32'hFFFF_FFC3, 0, RL + 2);

        repeat (5) @(negedge clk);
        check("resp_queue_empty", resp_q.size(), 32'd0);
        check("read_queue_empty", rd_q.size(), 32'd0);
        check("write_queue_empty", wr_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
